// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared scan state encoding for the LED matrix scanner.
package led_matrix_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: pixel/brightness inputs and row/column drive outputs of the scanner.
interface led_matrix_scanner_if #(
  parameter int ROWS     = 3,
  parameter int COLS     = 3,
  parameter int PWM_BITS = 4
);
  logic                 enable;
  logic [ROWS*COLS-1:0] segments;
  logic [PWM_BITS-1:0]  brightness;
  logic [ROWS-1:0]      rows;
  logic [COLS-1:0]      cols;
  logic                 frame_start;
  modport master (output enable, segments, brightness, input rows, cols, frame_start);
  modport slave  (input enable, segments, brightness, output rows, cols, frame_start);
endinterface

// File: rtl/led_pwm_compare.sv
// led_pwm_compare: brightness duty gate; full-scale level stays on for the whole window.
module led_pwm_compare #(
  parameter int PWM_BITS = 4
) (
  input  logic [PWM_BITS-1:0] phase_i,
  input  logic [PWM_BITS-1:0] level_i,
  output logic                pwm_on_o
);
  assign pwm_on_o = (phase_i < level_i) || (&level_i);
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: multiplexed row scan with blanking, per-frame input capture and PWM dimming.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int PWM_BITS     = 4
) (
  input logic                 clk,
  input logic                 reset,
  led_matrix_scanner_if.slave bus
);
  localparam int PMAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int RW   = $clog2(ROWS);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  scan_state_t          state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [RW-1:0]        row_q, row_d;
  logic [ROWS*COLS-1:0] frame_buf_q;
  logic [PWM_BITS-1:0]  bright_buf_q;
  logic [ROWS-1:0]      rows_q;
  logic [COLS-1:0]      cols_q, row_bits;
  logic                 frame_start_q, cap, pwm_on;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    row_d   = row_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        row_d   = '0;
        if (bus.enable) begin
          state_d = BLANK;
          cap     = 1'b1;
        end
      end
      BLANK: if (phase_q == BLANK_LAST) begin
        state_d = DRIVE;
        phase_d = '0;
      end
      DRIVE: if (phase_q == DWELL_LAST) begin
        state_d = BLANK;
        phase_d = '0;
        row_d   = row_q == ROW_LAST ? '0 : row_q + 1'b1;
        cap     = row_d == '0;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) begin
      state_d = IDLE;
      phase_d = '0;
      row_d   = '0;
      cap     = 1'b0;
    end
  end
  // Outputs are computed from next-state so they stay registered yet line up with the state.
  assign row_bits = frame_buf_q[int'(row_d)*COLS +: COLS];
  led_pwm_compare #(.PWM_BITS(PWM_BITS)) u_pwm (
    .phase_i (phase_d[PWM_BITS-1:0]),
    .level_i (bright_buf_q),
    .pwm_on_o(pwm_on)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      row_q         <= '0;
      frame_buf_q   <= '0;
      bright_buf_q  <= '0;
      rows_q        <= '0;
      cols_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      row_q         <= row_d;
      frame_buf_q   <= cap ? bus.segments : frame_buf_q;
      bright_buf_q  <= cap ? bus.brightness : bright_buf_q;
      rows_q        <= state_d == DRIVE ? ROWS'(1) << row_d : '0;
      cols_q        <= state_d == DRIVE ? ~(row_bits & {COLS{pwm_on}}) : '1;
      frame_start_q <= cap;
    end
  end
  assign bus.rows        = rows_q;
  assign bus.cols        = cols_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 3, number of anode rows (2..16).
REQ-002 SHALL have parameter COLS, default 3, number of cathode columns (1..16).
REQ-003 SHALL have parameter DWELL_CYCLES, default 1000, clocks per row drive window (>= 2^PWM_BITS).
REQ-004 SHALL have parameter BLANK_CYCLES, default 2, dark clocks before each row (>= 1).
REQ-005 SHALL have parameter PWM_BITS, default 4, brightness resolution.
REQ-006 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port enable, input, 1, scan run; low forces dark.
REQ-009 SHALL have port segments, input, ROWS*COLS, pixel r*COLS+c drives row r, column c; 1 = lit.
REQ-010 SHALL have port brightness, input, PWM_BITS, duty level.
REQ-011 SHALL have port rows, output, ROWS, active-high anode drive, at most one bit set.
REQ-012 SHALL have port cols, output, COLS, active-low cathode drive.
REQ-013 SHALL have port frame_start, output, 1, one-clock pulse when a new frame is latched.

Function
REQ-014 SHALL implement FSM states IDLE, BLANK, DRIVE; row_idx counter 0..ROWS-1; phase counter.
REQ-015 IDLE: rows = 0, cols = all ones; on enable=1 go to BLANK with row_idx = 0.
REQ-016 BLANK SHALL last exactly BLANK_CYCLES clocks with rows = 0, cols = all ones, then go to DRIVE.
REQ-017 DRIVE SHALL last exactly DWELL_CYCLES clocks; rows = one-hot(row_idx); cols[c] = ~(frame_buf[row_idx*COLS+c] & pwm_on).
REQ-018 pwm_on SHALL be 1 when phase[PWM_BITS-1:0] < bright_buf, or when bright_buf is all ones; brightness 0 gives fully dark.
REQ-019 At end of DRIVE, row_idx SHALL increment and go to BLANK; from ROWS-1 it SHALL wrap to 0.
REQ-020 On every entry to BLANK with row_idx = 0, including from IDLE, segments and brightness SHALL be captured into frame_buf and bright_buf, and frame_start SHALL pulse for that one clock.
REQ-021 Input changes mid-frame SHALL NOT affect outputs until the next capture, so there is no tearing.
REQ-022 Frame period SHALL be ROWS*(BLANK_CYCLES+DWELL_CYCLES) clocks.
REQ-023 rows, cols and frame_start SHALL be registered outputs, with no combinational path from inputs.
REQ-024 enable=0 in any state SHALL force IDLE on the next clock, with outputs dark on that clock's edge; re-enable SHALL restart at row 0 with a fresh capture.
REQ-025 Column bits SHALL be per-pixel, so only pixels set in the active row light; no OR-ing across rows.

Reset
REQ-026 reset SHALL set state IDLE, row_idx 0, phase 0, frame_buf 0, bright_buf 0, rows 0, cols all ones, frame_start 0.
REQ-027 reset SHALL take priority over enable; asserted mid-DRIVE it SHALL give dark outputs after the next edge.

Structure
REQ-028 Package led_matrix_pkg SHALL hold the scan_state_t enum (IDLE, BLANK, DRIVE).
REQ-029 Counter widths SHALL be derived with $clog2 locally from the parameters.
REQ-030 Sub-module led_pwm_compare (phase, level -> pwm_on) SHALL be instantiated once.

Verification (ROWS=3, COLS=3, DWELL_CYCLES=4, BLANK_CYCLES=1, PWM_BITS=2)
REQ-031 Reset, then enable=1, segments=9'b100_010_001, brightness=3 -> frame_start pulses every 15 clocks; row0 cols=3'b110, row1 3'b101, row2 3'b011, each for 4 clocks after 1 dark clock.
REQ-032 brightness=1, segments all ones -> per DRIVE window cols = 000 for 1 clock, then 111 for 3 clocks.
REQ-033 brightness=0 -> rows still scan, cols stay 111 throughout.
REQ-034 Change segments during row 1 DRIVE -> outputs unchanged until next frame_start, then new pattern appears.
REQ-035 Deassert enable mid-DRIVE of row 2 -> rows=0, cols=111 next clock; re-enable -> frame_start, and row 0 drives after 1 blank clock.
REQ-036 Assert reset mid-frame with enable=1 held -> all outputs take their reset values; scanning restarts at row 0 after release.
